// File: rtl/mdc_pkg.sv
// -----------------------------------------------------------------------------
// mdc_pkg
//   Shared definitions for the MDC determinant core and its result unpacker:
//   matrix-size codes, result/element widths, per-size element counts, the
//   buffered result entry type, the unpacker FSM state type and two helpers
//   that locate a minor determinant inside a packed result.
//   No ports (package).
// -----------------------------------------------------------------------------
package mdc_pkg;

   // Matrix-size codes carried alongside every MDC result (2'd3 also means 4x4).
   localparam logic [1:0] SIZE_2X2 = 2'd0;
   localparam logic [1:0] SIZE_3X3 = 2'd1;
   localparam logic [1:0] SIZE_4X4 = 2'd2;

   localparam int DET2_W  = 23;   // one 2x2 minor
   localparam int DET3_W  = 51;   // one 3x3 minor
   localparam int RES_W   = 207;  // packed MDC result
   localparam int ELEM_W  = 51;   // unpacked, sign-extended element
   localparam int IDX_W   = 4;    // element index within one result
   localparam int SIZE_W  = 2;

   // Elements carried by one result of each size.
   localparam int N_2X2 = 9;
   localparam int N_3X3 = 4;
   localparam int N_4X4 = 1;

   // One buffered result: the size travels with the data so the unpacker can
   // interpret the head entry long after the MDC pulse is gone.
   typedef struct packed {
      logic [SIZE_W-1:0] size;
      logic [RES_W-1:0]  data;
   } res_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Index of the final element for a given result size.
   function automatic logic [IDX_W-1:0] last_idx(input logic [SIZE_W-1:0] size);
      logic [IDX_W-1:0] r;
      case (size)
         SIZE_2X2: r = IDX_W'(N_2X2 - 1);
         SIZE_3X3: r = IDX_W'(N_3X3 - 1);
         default:  r = IDX_W'(N_4X4 - 1);
      endcase
      return r;
   endfunction

   // Element idx of a packed result, element 0 being the MSB-most field.
   //   2x2: 23-bit fields from bit 206 down, sign-extended.
   //   3x3: 51-bit fields from bit 203 down; bits [206:204] are padding.
   //   4x4: single value in the low 51 bits.
   function automatic logic [ELEM_W-1:0] extract_elem(input logic [RES_W-1:0]  data,
                                                       input logic [SIZE_W-1:0] size,
                                                       input logic [IDX_W-1:0]  idx);
      logic [DET2_W-1:0] f2;
      logic [ELEM_W-1:0] r;
      f2 = '0;
      r  = '0;
      case (size)
         SIZE_2X2: begin
            f2 = DET2_W'(data >> (DET2_W * ((N_2X2 - 1) - int'(idx))));
            r  = {{(ELEM_W - DET2_W){f2[DET2_W-1]}}, f2};
         end
         SIZE_3X3: r = ELEM_W'(data >> (DET3_W * ((N_3X3 - 1) - int'(idx))));
         default:  r = data[ELEM_W-1:0];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mdc_res_fifo.sv
// -----------------------------------------------------------------------------
// mdc_res_fifo
//   Two-entry register FIFO holding complete MDC results ({size, data}).
//   A push into a full FIFO is taken only when a pop happens in the same cycle.
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset (empties the FIFO)
//   push        in   write push_entry at the tail
//   push_entry  in   result to store
//   pop         in   discard the head entry
//   head        out  current head entry (valid while !empty)
//   full        out  both entries occupied
//   empty       out  no entries occupied
// -----------------------------------------------------------------------------
module mdc_res_fifo
   import mdc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  res_entry_t push_entry,
   input  logic       pop,
   output res_entry_t head,
   output logic       full,
   output logic       empty
);

   res_entry_t mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: storage has no reset; emptiness is tracked by count alone, so stale
   // contents are never observed and the wide data path stays reset-free.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/mdc_result_unpacker.sv
// -----------------------------------------------------------------------------
// mdc_result_unpacker
//   Captures one-cycle MDC result pulses into a 2-deep buffer and streams each
//   result out as individual sign-extended minor determinants, one per
//   valid/ready beat, element 0 (MSB field) first.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   one-cycle result pulse from MDC
//   in_data    in   packed 207-bit result
//   in_size    in   matrix size: 0=2x2, 1=3x3, 2/3=4x4
//   out_valid  out  element available
//   out_ready  in   downstream accepts element
//   out_data   out  51-bit signed element
//   out_idx    out  element index within the result
//   out_last   out  final element of the current result
//   overflow   out  sticky: a result was dropped on a full buffer
// -----------------------------------------------------------------------------
module mdc_result_unpacker
   import mdc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [RES_W-1:0]  in_data,
   input  logic [SIZE_W-1:0] in_size,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ELEM_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic              overflow
);

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             overflow_q;

   res_entry_t       head;
   res_entry_t       push_entry;
   logic             full;
   logic             empty;
   logic             is_last;
   logic             fire;
   logic             pop;
   logic             push_acc;

   assign push_entry = '{size: in_size, data: in_data};
   assign is_last    = (idx_q == last_idx(head.size));
   assign fire       = (state_q == ST_EMIT) && out_ready;
   assign pop        = fire && is_last;
   // A full buffer still accepts a result when the head retires this cycle.
   assign push_acc   = in_valid && (!full || pop);

   mdc_res_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_acc),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (in_valid && full && !pop) overflow_q <= 1'b1;
      end
   end

   // Next state. IDLE is left on the capturing edge itself so element 0 is
   // presented the cycle after the pulse. After the last beat, EMIT continues
   // without a bubble if another result is buffered or arriving.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (push_acc || !empty) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (fire) idx_d = is_last ? '0 : idx_q + IDX_W'(1);
            if (pop && !(full || push_acc)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs depend only on flops (state, counter, head entry), so they hold
   // steady while out_ready is low and read 0 whenever nothing is offered.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      if (state_q == ST_EMIT) begin
         out_valid = 1'b1;
         out_data  = extract_elem(head.data, head.size, idx_q);
         out_idx   = idx_q;
         out_last  = is_last;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_mdc_result_unpacker.sv
// -----------------------------------------------------------------------------
// tb_mdc_result_unpacker
//   Directed self-checking bench. Inputs are driven and outputs sampled on the
//   falling clock edge; every beat is compared as {valid, idx, last, data}.
// -----------------------------------------------------------------------------
module tb_mdc_result_unpacker;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [206:0] in_data;
   logic [1:0]   in_size;
   logic         out_valid;
   logic         out_ready;
   logic [50:0]  out_data;
   logic [3:0]   out_idx;
   logic         out_last;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   mdc_result_unpacker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_size   (in_size),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // 2x2 result whose field k (MSB first) holds base + k*step.
   function automatic logic [206:0] pack2x2(input int base, input int step);
      logic [206:0] d;
      d = '0;
      for (int k = 0; k < 9; k++) d[206-23*k -: 23] = 23'(base + k * step);
      return d;
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_size   = 2'd0;
      out_ready = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_idx, out_last, out_data, overflow} !== 58'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b i=%0d l=%b d=%h o=%b exp all 0",
                  out_valid, out_idx, out_last, out_data, overflow);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_valid got %b exp 0", out_valid);
      end
   endtask

   // T1: 2x2 fields 1..9 at full rate.
   task automatic test_size0_fields();
      logic [56:0] exp;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t1_pre_valid got %b exp 0", out_valid);
      end
      out_ready = 1'b1;
      in_size   = 2'd0;
      in_data   = pack2x2(1, 1);
      in_valid  = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         exp = {1'b1, 4'(k), (k == 8), 51'(k + 1)};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL t1_beat%0d got %h exp %h", k,
                     {out_valid, out_idx, out_last, out_data}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t1_post_valid got %b exp 0", out_valid);
      end
   endtask

   // T2: 3x3 fields {-5, 7, 0, -1} with padding bits set.
   task automatic test_size1_fields();
      logic [50:0] vals [4];
      logic [56:0] exp;
      vals[0] = 51'h7FFFFFFFFFFFB;
      vals[1] = 51'd7;
      vals[2] = 51'd0;
      vals[3] = 51'h7FFFFFFFFFFFF;
      out_ready = 1'b1;
      in_size   = 2'd1;
      in_data   = {3'b111, vals[0], vals[1], vals[2], vals[3]};
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         exp = {1'b1, 4'(k), (k == 3), vals[k]};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL t2_beat%0d got %h exp %h", k,
                     {out_valid, out_idx, out_last, out_data}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t2_post_valid got %b exp 0", out_valid);
      end
   endtask

   // T3: 4x4 single element, negative value.
   task automatic test_size2_single();
      logic signed [206:0] v;
      logic [56:0]         exp;
      v         = -123456789;
      out_ready = 1'b1;
      in_size   = 2'd2;
      in_data   = v;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp = {1'b1, 4'd0, 1'b1, 51'h7FFFFF8A432EB};
      checks++;
      if ({out_valid, out_idx, out_last, out_data} !== exp) begin
         errors++;
         $display("FAIL t3_beat got %h exp %h", {out_valid, out_idx, out_last, out_data}, exp);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t3_post_valid got %b exp 0", out_valid);
      end
   endtask

   // T4: two 2x2 results 18 cycles apart while stalled 30 cycles, then drain.
   task automatic test_back_to_back();
      logic [56:0] exp;
      int          base;
      int          step;
      int          bad_hold;
      bad_hold  = 0;
      out_ready = 1'b0;
      in_size   = 2'd0;
      in_data   = pack2x2(100, 1);
      in_valid  = 1'b1;
      for (int c = 1; c < 30; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if ({out_valid, out_idx, out_last, out_data} !== {1'b1, 4'd0, 1'b0, 51'd100})
            bad_hold++;
         if (c == 18) begin
            in_data  = pack2x2(-50, -3);
            in_valid = 1'b1;
         end
      end
      checks++;
      if (bad_hold !== 0) begin
         errors++;
         $display("FAIL t4_hold_stable got %0d unstable cycles exp 0", bad_hold);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL t4_overflow_stall got %b exp 0", overflow);
      end
      out_ready = 1'b1;
      for (int b = 0; b < 18; b++) begin
         if (b > 0) @(negedge clk);
         base = (b < 9) ? 100 : -50;
         step = (b < 9) ? 1 : -3;
         exp  = {1'b1, 4'(b % 9), ((b % 9) == 8), 51'(base + (b % 9) * step)};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL t4_beat%0d got %h exp %h", b,
                     {out_valid, out_idx, out_last, out_data}, exp);
         end
      end
      @(negedge clk);
      checks++;
      if ({out_valid, overflow} !== 2'b00) begin
         errors++;
         $display("FAIL t4_post got v=%b o=%b exp 0 0", out_valid, overflow);
      end
   endtask

   // T5: third result dropped on a full buffer; a result arriving with the
   // head's last handshake is accepted.
   task automatic test_overflow();
      logic [56:0] exp;
      logic [50:0] a_vals [4];
      a_vals[0] = 51'd11;
      a_vals[1] = 51'd22;
      a_vals[2] = 51'd33;
      a_vals[3] = 51'd44;
      out_ready = 1'b0;
      in_size   = 2'd1;
      in_data   = {3'b000, a_vals[0], a_vals[1], a_vals[2], a_vals[3]};
      in_valid  = 1'b1;
      @(negedge clk);
      in_size = 2'd2;
      in_data = 207'd555;
      @(negedge clk);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL t5_overflow_before got %b exp 0", overflow);
      end
      in_size = 2'd0;
      in_data = pack2x2(1000, 1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL t5_overflow_set got %b exp 1", overflow);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         exp = {1'b1, 4'(k), (k == 3), a_vals[k]};
         checks++;
         if ({out_valid, out_idx, out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL t5_a_beat%0d got %h exp %h", k,
                     {out_valid, out_idx, out_last, out_data}, exp);
         end
         if (k == 3) begin
            in_size  = 2'd3;
            in_data  = -207'sd7;
            in_valid = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      exp = {1'b1, 4'd0, 1'b1, 51'd555};
      checks++;
      if ({out_valid, out_idx, out_last, out_data} !== exp) begin
         errors++;
         $display("FAIL t5_b_beat got %h exp %h", {out_valid, out_idx, out_last, out_data}, exp);
      end
      @(negedge clk);
      exp = {1'b1, 4'd0, 1'b1, 51'h7FFFFFFFFFFF9};
      checks++;
      if ({out_valid, out_idx, out_last, out_data} !== exp) begin
         errors++;
         $display("FAIL t5_d_beat got %h exp %h", {out_valid, out_idx, out_last, out_data}, exp);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, overflow} !== 2'b01) begin
         errors++;
         $display("FAIL t5_post got v=%b o=%b exp v=0 o=1", out_valid, overflow);
      end
   endtask

   // T6: reset at idx 4 of a 2x2 result.
   task automatic test_reset_mid_emit();
      int bad_idle;
      bad_idle  = 0;
      out_ready = 1'b1;
      in_size   = 2'd0;
      in_data   = pack2x2(21, 1);
      in_valid  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      checks++;
      if ({out_valid, out_idx, out_data} !== {1'b1, 4'd4, 51'd25}) begin
         errors++;
         $display("FAIL t6_pre_reset got v=%b i=%0d d=%h exp v=1 i=4 d=19",
                  out_valid, out_idx, out_data);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_idx, out_last, out_data, overflow} !== 58'd0) begin
         errors++;
         $display("FAIL t6_reset_outputs got v=%b i=%0d l=%b d=%h o=%b exp all 0",
                  out_valid, out_idx, out_last, out_data, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad_idle++;
      end
      checks++;
      if (bad_idle !== 0) begin
         errors++;
         $display("FAIL t6_idle_after_release got %0d valid cycles exp 0", bad_idle);
      end
      in_data  = pack2x2(7, 7);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_idx, out_last, out_data} !== {1'b1, 4'd0, 1'b0, 51'd7}) begin
         errors++;
         $display("FAIL t6_fresh_beat got %h exp %h",
                  {out_valid, out_idx, out_last, out_data}, {1'b1, 4'd0, 1'b0, 51'd7});
      end
      repeat (9) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL t6_post_valid got %b exp 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_size0_fields();
      test_size1_fields();
      test_size2_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid_emit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
